gf180mcu_osu_sc_12t_cellbist4: RTL and testbench
================================================

Name: gf180mcu_osu_sc_12T_cellbist4

Overview:
- Built-in self-test sequencer for one 4-input combinational standard cell (default: aoi31, Y = ~((A0&A1&A2)|B)).
- Drives every input vector in turn, waits a programmable settle time, samples the cell output and compares it against an expected truth table.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the cell under test in the library's silicon test structures. The same block is reused for any 4-input cell by changing EXP_TT.

Parameters:
- NIN, 4: number of cell inputs. VEC width is NIN; there are 2^NIN vectors.
- SETTLE, 2: WAIT cycles between applying a vector and sampling Y_DUT. Legal range is 0..15.
- EXP_TT, 16'h007F: expected output. Bit i is the expected Y_DUT for VEC==i. VEC[0]=A0, [1]=A1, [2]=A2, [3]=B.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- START  input  1  begin a sweep; sampled only in IDLE or DONE.
- ABORT  input  1  synchronous abort; highest priority after reset.
- Y_DUT  input  1  output of the cell under test.
- VEC  output  NIN  applied input vector to the cell (registered).
- BUSY  output  1  high in WAIT or CHECK.
- DONE  output  1  high in DONE state.
- PASS  output  1  valid when DONE=1; equals (ERRCNT==0).
- ERRCNT  output  NIN+1  mismatch count for the current/last sweep.
- FIRSTFAIL  output  NIN  vector index of the first mismatch.
- FAILVALID  output  1  high once FIRSTFAIL holds a captured value.

Behaviour:
- Reset (RN=0, asynchronous):
  - State IDLE; VEC=0; BUSY=0; DONE=0; PASS=0; ERRCNT=0; FIRSTFAIL=0; FAILVALID=0; settle counter=0.
  - Reset takes effect immediately, including mid-sweep. No partial results survive.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE or DONE with START=1 at an edge:
  - VEC<=0, ERRCNT<=0, FAILVALID<=0, FIRSTFAIL<=0, DONE<=0.
  - Next state is WAIT with counter=SETTLE. If SETTLE==0, go straight to CHECK.
- START is ignored in WAIT and CHECK.
- WAIT: counter decrements each cycle. At the edge where counter==1, go to CHECK. WAIT lasts exactly SETTLE cycles.
- CHECK (1 cycle): compare Y_DUT with EXP_TT[VEC].
  - On mismatch: ERRCNT<=ERRCNT+1. ERRCNT is NIN+1 bits wide so it cannot overflow (max 16).
  - On mismatch with FAILVALID==0: also FIRSTFAIL<=VEC and FAILVALID<=1.
  - If VEC==2^NIN-1, go to DONE.
  - Otherwise VEC<=VEC+1 and go to WAIT (or stay in CHECK when SETTLE==0).
  - VEC does not wrap inside a sweep.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - DONE rises on edge number 2^NIN*(SETTLE+1) after the edge that sampled START. Default: 48.
- DONE state:
  - VEC holds the last vector; ERRCNT, FIRSTFAIL and FAILVALID hold.
  - PASS=(ERRCNT==0), registered on DONE entry.
  - Stays in DONE until START, ABORT or reset.
- ABORT=1 at any edge (any state):
  - Go to IDLE; VEC<=0; BUSY=0; DONE=0; PASS=0.
  - ERRCNT, FIRSTFAIL and FAILVALID hold their partial values.
- START and ABORT high together: ABORT wins.
- BUSY is the registered decode of the WAIT/CHECK states. It is high from the cycle after START is sampled until DONE rises.
- Y_DUT is sampled only in CHECK.
- Y_DUT is asynchronous to the sweep only through the settle delay. No synchronizer is required because Y_DUT is a combinational function of VEC.

Test Plan:
- Golden aoi31 model on Y_DUT, defaults, START pulse -> DONE at 48 cycles; PASS=1, ERRCNT=0, FAILVALID=0, VEC=15.
- Y_DUT stuck at 0 -> ERRCNT=7 (vectors 0..6), FIRSTFAIL=0, FAILVALID=1, PASS=0.
- Y_DUT stuck at 1 -> ERRCNT=9 (vectors 7..15), FIRSTFAIL=7, PASS=0.
- SETTLE=0 with golden model -> DONE at 16 cycles, PASS=1. Then a second START from DONE -> counters clear and the sweep repeats identically.
- Model with only vector 12 inverted, ABORT at cycle 20 -> IDLE, VEC=0, DONE=0, ERRCNT=0. Rerun to completion -> ERRCNT=1, FIRSTFAIL=12. ABORT together with START in IDLE -> stays IDLE.
- RN pulsed low mid-sweep (cycle 30, stuck-at-0 DUT) -> all outputs at reset values immediately. START after release -> full sweep, ERRCNT=7.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_cellbist4_if.sv
// Tester-side bundle for the 4-input cell BIST: sweep control, the cell
// under test (VEC out, Y_DUT back) and the sweep result registers.
interface gf180mcu_osu_sc_12t_cellbist4_if #(
  parameter int NIN = 4
);
  logic           START;
  logic           ABORT;
  logic           Y_DUT;
  logic [NIN-1:0] VEC;
  logic           BUSY;
  logic           DONE;
  logic           PASS;
  logic [NIN:0]   ERRCNT;
  logic [NIN-1:0] FIRSTFAIL;
  logic           FAILVALID;

  // The BIST sequencer owns the vector and result side.
  modport master (
    input  START, ABORT, Y_DUT,
    output VEC, BUSY, DONE, PASS, ERRCNT, FIRSTFAIL, FAILVALID
  );

  // The test controller / cell harness side.
  modport slave (
    output START, ABORT, Y_DUT,
    input  VEC, BUSY, DONE, PASS, ERRCNT, FIRSTFAIL, FAILVALID
  );
endinterface

// File: rtl/gf180mcu_osu_sc_12t_cellbist4.sv
// Exhaustive-sweep BIST for one NIN-input combinational cell: applies every
// vector, waits SETTLE cycles, compares Y_DUT against EXP_TT and logs errors.
module gf180mcu_osu_sc_12t_cellbist4 #(
  parameter int                     NIN    = 4,
  parameter int                     SETTLE = 2,
  parameter logic [(1<<NIN)-1:0]    EXP_TT = 16'h007F
) (
  input  logic CLK,
  input  logic RN,
  gf180mcu_osu_sc_12t_cellbist4_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [NIN-1:0] VEC_LAST   = {NIN{1'b1}};
  localparam logic [NIN-1:0] VEC_ONE    = NIN'(1);
  localparam logic [NIN:0]   ERR_ZERO   = '0;
  localparam logic [NIN:0]   ERR_ONE    = (NIN+1)'(1);
  localparam logic [3:0]     SETTLE_CNT = 4'(SETTLE);
  localparam logic [3:0]     CNT_ONE    = 4'd1;
  // With no settle time every cycle is a compare cycle.
  localparam state_t         ST_NEXT_VEC = (SETTLE == 0) ? ST_CHECK : ST_WAIT;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [NIN-1:0] vec_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic [NIN:0]   errcnt_q;
  logic [NIN-1:0] firstfail_q;
  logic           failvalid_q;

  logic           mismatch;
  logic [NIN:0]   errcnt_nxt;

  function automatic logic [NIN:0] err_accum(input logic [NIN:0] cnt,
                                             input logic         miss);
    return miss ? (cnt + ERR_ONE) : cnt;
  endfunction

  assign mismatch   = (bus.Y_DUT != EXP_TT[vec_q]);
  assign errcnt_nxt = err_accum(errcnt_q, mismatch);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errcnt_q    <= '0;
      firstfail_q <= '0;
      failvalid_q <= 1'b0;
    end else if (bus.ABORT) begin
      // Partial error results are kept for post-mortem inspection.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state_q     <= ST_NEXT_VEC;
            cnt_q       <= SETTLE_CNT;
            vec_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errcnt_q    <= '0;
            firstfail_q <= '0;
            failvalid_q <= 1'b0;
          end
        end

        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          errcnt_q <= errcnt_nxt;
          if (mismatch && !failvalid_q) begin
            firstfail_q <= vec_q;
            failvalid_q <= 1'b1;
          end
          if (vec_q == VEC_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errcnt_nxt == ERR_ZERO);
          end else begin
            state_q <= ST_NEXT_VEC;
            cnt_q   <= SETTLE_CNT;
            vec_q   <= vec_q + VEC_ONE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.VEC       = vec_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.ERRCNT    = errcnt_q;
  assign bus.FIRSTFAIL = firstfail_q;
  assign bus.FAILVALID = failvalid_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_cellbist4.sv
// Bench for the cell BIST: an aoi31 cell model with injectable faults drives
// two sequencers (SETTLE=2 and SETTLE=0); results are checked against a model.
module tb_gf180mcu_osu_sc_12t_cellbist4;

  logic        clk = 1'b0;
  logic        rn  = 1'b0;
  logic        start2 = 1'b0, abort2 = 1'b0;
  logic        start0 = 1'b0, abort0 = 1'b0;
  int          mode = 0;          // 0: aoi31 ^ flip, 1: stuck-at-0, 2: stuck-at-1
  logic [15:0] flip = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_cellbist4_if #(.NIN(4)) if2 ();
  gf180mcu_osu_sc_12t_cellbist4_if #(.NIN(4)) if0 ();

  function automatic logic aoi31(input logic [3:0] v);
    return !((v[0] & v[1] & v[2]) | v[3]);
  endfunction

  assign if2.START = start2;
  assign if2.ABORT = abort2;
  assign if2.Y_DUT = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (aoi31(if2.VEC) ^ flip[if2.VEC]);
  assign if0.START = start0;
  assign if0.ABORT = abort0;
  assign if0.Y_DUT = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (aoi31(if0.VEC) ^ flip[if0.VEC]);

  gf180mcu_osu_sc_12t_cellbist4 #(.NIN(4), .SETTLE(2), .EXP_TT(16'h007F)) u_dut2 (
    .CLK (clk),
    .RN  (rn),
    .bus (if2)
  );

  gf180mcu_osu_sc_12t_cellbist4 #(.NIN(4), .SETTLE(0), .EXP_TT(16'h007F)) u_dut0 (
    .CLK (clk),
    .RN  (rn),
    .bus (if0)
  );

  typedef struct {
    int          mode;
    logic [15:0] flip;
    int          exp_err;
    int          exp_first;
    int          exp_fv;
    int          exp_pass;
  } tv_t;

  tv_t tbl [6];

  function automatic int o_vec(input int s);  return (s == 0) ? int'(if0.VEC)       : int'(if2.VEC);       endfunction
  function automatic int o_busy(input int s); return (s == 0) ? int'(if0.BUSY)      : int'(if2.BUSY);      endfunction
  function automatic int o_done(input int s); return (s == 0) ? int'(if0.DONE)      : int'(if2.DONE);      endfunction
  function automatic int o_pass(input int s); return (s == 0) ? int'(if0.PASS)      : int'(if2.PASS);      endfunction
  function automatic int o_err(input int s);  return (s == 0) ? int'(if0.ERRCNT)    : int'(if2.ERRCNT);    endfunction
  function automatic int o_ff(input int s);   return (s == 0) ? int'(if0.FIRSTFAIL) : int'(if2.FIRSTFAIL); endfunction
  function automatic int o_fv(input int s);   return (s == 0) ? int'(if0.FAILVALID) : int'(if2.FAILVALID); endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v; else start2 = v;
  endtask

  task automatic set_abort(input int s, input logic v);
    if (s == 0) abort0 = v; else abort2 = v;
  endtask

  // Reference: the cell's intended function is aoi31; count every vector
  // where the faulted cell disagrees and remember the lowest such vector.
  task automatic model_expect(output int e, output int f, output int fv);
    logic y;
    e = 0; f = 0; fv = 0;
    for (int v = 0; v < 16; v++) begin
      if (mode == 1)      y = 1'b0;
      else if (mode == 2) y = 1'b1;
      else                y = aoi31(4'(v)) ^ flip[v];
      if (y != aoi31(4'(v))) begin
        if (fv == 0) begin f = v; fv = 1; end
        e++;
      end
    end
  endtask

  task automatic check_reset_vals(input int s, input string tag);
    check({tag, "_vec"},  o_vec(s),  0);
    check({tag, "_busy"}, o_busy(s), 0);
    check({tag, "_done"}, o_done(s), 0);
    check({tag, "_pass"}, o_pass(s), 0);
    check({tag, "_err"},  o_err(s),  0);
    check({tag, "_ff"},   o_ff(s),   0);
    check({tag, "_fv"},   o_fv(s),   0);
  endtask

  // Pulse START, then count edges until DONE rises (bounded).
  task automatic run_sweep(input int s, input int exp_cycles, input string tag);
    int n;
    int busy_ok;
    set_start(s, 1'b1);
    step();
    set_start(s, 1'b0);
    check({tag, "_start_err"},  o_err(s),  0);
    check({tag, "_start_done"}, o_done(s), 0);
    n = 0;
    busy_ok = (o_busy(s) == 1) ? 1 : 0;
    while (n < 200) begin
      step();
      n++;
      if (o_done(s) == 1) break;
      if (o_busy(s) != 1) busy_ok = 0;
    end
    check({tag, "_cycles"},    n, exp_cycles);
    check({tag, "_busy_hi"},   busy_ok, 1);
    check({tag, "_busy_done"}, o_busy(s), 0);
  endtask

  task automatic check_results(input int s, input string tag,
                               input int e, input int f, input int fv, input int p);
    check({tag, "_vec"},  o_vec(s), 15);
    check({tag, "_err"},  o_err(s), e);
    check({tag, "_fv"},   o_fv(s),  fv);
    if (fv != 0) check({tag, "_ff"}, o_ff(s), f);
    check({tag, "_pass"}, o_pass(s), p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, f, fv;

    tbl[0] = '{0, 16'h0000, 0, 0, 0, 1};
    tbl[1] = '{1, 16'h0000, 7, 0, 1, 0};
    tbl[2] = '{2, 16'h0000, 9, 7, 1, 0};
    tbl[3] = '{0, 16'h1000, 1, 12, 1, 0};
    tbl[4] = '{0, 16'h8001, 2, 0, 1, 0};
    tbl[5] = '{0, 16'hFFFF, 16, 0, 1, 0};

    #2;
    check_reset_vals(2, "reset");
    step();
    step();
    rn = 1'b1;
    step();
    check_reset_vals(2, "idle");

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      flip = tbl[i].flip;
      run_sweep(2, 48, $sformatf("tbl%0d", i));
      check_results(2, $sformatf("tbl%0d", i), tbl[i].exp_err, tbl[i].exp_first,
                    tbl[i].exp_fv, tbl[i].exp_pass);
    end

    for (int r = 0; r < 6; r++) begin
      mode = 0;
      flip = 16'($urandom & $urandom & $urandom);
      model_expect(e, f, fv);
      run_sweep(2, 48, $sformatf("rnd%0d", r));
      check_results(2, $sformatf("rnd%0d", r), e, f, fv, (e == 0) ? 1 : 0);
    end
    mode = 2;
    model_expect(e, f, fv);
    run_sweep(2, 48, "rnd_s1");
    check_results(2, "rnd_s1", e, f, fv, 0);

    // Zero settle time: one vector per cycle, repeated START from DONE.
    mode = 0; flip = '0;
    run_sweep(0, 16, "s0_a");
    check_results(0, "s0_a", 0, 0, 0, 1);
    mode = 1;
    run_sweep(0, 16, "s0_b");
    check_results(0, "s0_b", 7, 0, 1, 0);
    mode = 0;
    run_sweep(0, 16, "s0_c");
    check_results(0, "s0_c", 0, 0, 0, 1);

    // Abort partway through a sweep with a single-vector fault at 12.
    mode = 0; flip = 16'h1000;
    set_start(2, 1'b1);
    step();
    set_start(2, 1'b0);
    for (int k = 0; k < 20; k++) step();
    abort2 = 1'b1;
    step();
    abort2 = 1'b0;
    check("abort_vec",  o_vec(2),  0);
    check("abort_busy", o_busy(2), 0);
    check("abort_done", o_done(2), 0);
    check("abort_err",  o_err(2),  0);
    check("abort_fv",   o_fv(2),   0);
    step(); step();
    check("abort_idle_busy", o_busy(2), 0);
    check("abort_idle_vec",  o_vec(2),  0);
    run_sweep(2, 48, "rerun");
    check_results(2, "rerun", 1, 12, 1, 0);

    // Abort from DONE keeps the logged errors; ABORT beats START.
    abort2 = 1'b1;
    step();
    abort2 = 1'b0;
    check("abort_done_done", o_done(2), 0);
    check("abort_done_pass", o_pass(2), 0);
    check("abort_done_err",  o_err(2),  1);
    check("abort_done_ff",   o_ff(2),   12);
    abort2 = 1'b1; start2 = 1'b1;
    step();
    abort2 = 1'b0; start2 = 1'b0;
    check("abst_busy", o_busy(2), 0);
    check("abst_done", o_done(2), 0);
    step(); step(); step();
    check("abst_busy_later", o_busy(2), 0);
    check("abst_err_held",   o_err(2),  1);

    // Asynchronous reset mid-sweep with a stuck-at-0 cell.
    mode = 1; flip = '0;
    set_start(2, 1'b1);
    step();
    set_start(2, 1'b0);
    for (int k = 0; k < 30; k++) step();
    check("pre_rst_busy", o_busy(2), 1);
    #2;
    rn = 1'b0;
    #1;
    check_reset_vals(2, "async_rst");
    step();
    rn = 1'b1;
    step();
    run_sweep(2, 48, "post_rst");
    check_results(2, "post_rst", 7, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
